// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI driver arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_EN,
        S_XFER,
        S_RESP,
        S_GAP,
        S_HOLD
    } state_t;

    localparam int NUM_REQ_DEF       = 4;
    localparam int START_TIMEOUT_DEF = 8;
    localparam int GAP_CYCLES_DEF    = 2;
    localparam int TO_W              = $clog2(START_TIMEOUT_DEF + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last winner.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    logic found;

    // Candidate i sits k places after ptr when ptr == (i - k) mod NUM_REQ.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (ptr == IW'((i + NUM_REQ - k) % NUM_REQ))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one single-byte SPI master driver between NUM_REQ requesters,
// with round-robin grants, burst locking and a driver start timeout.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 drv_start,
    output logic [7:0]           drv_data_in,
    input  logic                 drv_en,
    input  logic [7:0]           drv_data_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      src_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [NUM_REQ-1:0] owner_oh;
    logic [7:0]         src_data;
    logic [7:0]         cap;
    logic               src_last;
    logic               last_q;
    logic               err_q;
    logic               accept;
    logic [TW-1:0]      to_cnt;
    logic [GW-1:0]      gap_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // In HOLD only the burst owner can be accepted; in IDLE the arbiter decides.
    always_comb begin
        owner_oh  = '0;
        req_ready = '0;
        src_data  = '0;
        src_last  = 1'b0;
        src_idx   = (state == S_HOLD) ? owner : arb_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) owner_oh[i] = 1'b1;
            if (src_idx == IW'(i)) begin
                src_data = req_data[i*8 +: 8];
                src_last = req_last[i];
            end
        end
        if (state == S_IDLE)
            req_ready = arb_grant;
        else if (state == S_HOLD)
            req_ready = owner_oh & req_valid;
        accept = |req_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= IW'(NUM_REQ - 1);
            owner       <= '0;
            cap         <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            drv_start   <= 1'b0;
            drv_data_in <= '0;
        end else begin
            drv_start <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        drv_data_in <= src_data;
                        last_q      <= src_last;
                        err_q       <= 1'b0;
                        drv_start   <= 1'b1;
                        state       <= S_LAUNCH;
                        if (state == S_IDLE) begin
                            owner <= arb_idx;
                            ptr   <= arb_idx;
                        end
                    end
                end
                S_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_EN;
                end
                // Capture here too so a one-cycle enable still delivers its byte.
                S_WAIT_EN: begin
                    if (drv_en) begin
                        cap   <= drv_data_out;
                        state <= S_XFER;
                    end else if (to_cnt == TW'(START_TIMEOUT - 1)) begin
                        err_q     <= 1'b1;
                        rsp_valid <= owner_oh;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (drv_en) begin
                        cap <= drv_data_out;
                    end else begin
                        rsp_valid <= owner_oh;
                        rsp_data  <= cap;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1))
                        state <= (!last_q && !err_q) ? S_HOLD : S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural driver, requester agents and a transaction-level model.
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int N   = NUM_REQ_DEF;
    localparam int TO  = START_TIMEOUT_DEF;
    localparam int GAP = GAP_CYCLES_DEF;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           drv_start;
    logic [7:0]     drv_data_in;
    logic           drv_en;
    logic [7:0]     drv_data_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    spi_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .drv_start    (drv_start),
        .drv_data_in  (drv_data_in),
        .drv_en       (drv_en),
        .drv_data_out (drv_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Driver: enable rises the cycle after start, stays high drvLen cycles,
    // and the real byte appears only in the final enabled cycle.
    int         drvLen = 4;
    bit         drvMode = 1'b0;
    logic [7:0] drvByte = 8'h00;
    logic [7:0] drvFill = 8'h00;
    int         drvRemain = 0;
    bit         drvPending = 1'b0;

    always @(negedge clk) if (!rst && drv_start && !drvMode) drvPending = 1'b1;

    initial begin
        drv_en = 1'b0;
        drv_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                drvPending = 1'b0;
                drvRemain = 0;
            end else if (drvPending) begin
                drvPending = 1'b0;
                drvRemain = drvLen;
            end
            if (drvRemain > 0) begin
                drv_en = 1'b1;
                drv_data_out = (drvRemain == 1) ? drvByte : drvFill;
                drvRemain--;
            end else begin
                drv_en = 1'b0;
                drv_data_out = 8'h00;
            end
        end
    end

    // Requesters: each holds its head byte valid until it sees req_ready.
    logic [8:0]   reqQ [N][$];
    logic [N-1:0] accSeen;

    initial begin
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk);
            accSeen = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (accSeen[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
                if (reqQ[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*8 +: 8] = reqQ[i][0][7:0];
                    req_last[i] = reqQ[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input int who, input logic [7:0] data, input logic last);
        reqQ[who].push_back({last, data});
    endtask

    // Transaction model: who may be accepted when, what the driver sees, and what comes back.
    int         mPtr = N - 1;
    int         mLock = -1;
    int         mOwner = 0;
    int         mFreeCyc = 0;
    int         mStartCyc = -1;
    int         mRspCyc = -1;
    bit         mBusy = 1'b0;
    bit         mLast = 1'b0;
    bit         mErr = 1'b0;
    logic [7:0] mData = 8'h00;
    logic [7:0] mByte = 8'h00;

    int         grantLog[$];
    int         rspLog[$];
    int         startCount = 0;
    int         rspCount = 0;
    int         lastStartCyc = 0;
    int         lastRspCyc = 0;
    int         lastEnHighCyc = -1;
    logic [7:0] lastStartData = 8'h00;
    logic [N-1:0] lastRspValid = '0;
    logic [7:0] lastRspData = 8'h00;
    logic       lastRspErr = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] expReady;
        logic [N-1:0] expRsp;
        int w;
        if (rst) begin
            checkOutput("rst_req_ready", req_ready, 0);
            checkOutput("rst_rsp_valid", rsp_valid, 0);
            checkOutput("rst_rsp_data", rsp_data, 0);
            checkOutput("rst_rsp_err", rsp_err, 0);
            checkOutput("rst_drv_start", drv_start, 0);
            checkOutput("rst_drv_data_in", drv_data_in, 0);
            mPtr = N - 1;
            mLock = -1;
            mBusy = 1'b0;
            mFreeCyc = 0;
            mStartCyc = -1;
            mRspCyc = -1;
            lastEnHighCyc = -1;
        end else begin
            expReady = '0;
            w = 0;
            if (!mBusy && cyc >= mFreeCyc) begin
                if (mLock >= 0) begin
                    if (req_valid[mLock]) expReady[mLock] = 1'b1;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        w = (mPtr + k) % N;
                        if (expReady == '0 && req_valid[w]) expReady[w] = 1'b1;
                    end
                end
            end
            checkOutput("req_ready", req_ready, expReady);
            if (expReady != '0) begin
                for (int i = 0; i < N; i++) if (expReady[i]) w = i;
                mBusy = 1'b1;
                mOwner = w;
                mData = req_data[w*8 +: 8];
                mLast = req_last[w];
                if (mLock < 0) mPtr = w;
                mStartCyc = cyc + 1;
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) grantLog.push_back(i);

            checkOutput("drv_start", drv_start, cyc == mStartCyc);
            if (drv_start) begin
                startCount++;
                lastStartCyc = cyc;
                lastStartData = drv_data_in;
                if (lastEnHighCyc >= 0)
                    checkOutput("idle_before_start", (cyc - lastEnHighCyc - 1) >= GAP, 1);
            end
            if (cyc == mStartCyc) begin
                checkOutput("drv_data_in", drv_data_in, mData);
                mErr = drvMode;
                mByte = drvMode ? 8'h00 : drvByte;
                mRspCyc = drvMode ? (cyc + 1 + TO) : (cyc + drvLen + 2);
            end

            expRsp = '0;
            if (mBusy && cyc == mRspCyc) expRsp[mOwner] = 1'b1;
            checkOutput("rsp_valid", rsp_valid, expRsp);
            if (rsp_valid != '0) begin
                rspCount++;
                lastRspValid = rsp_valid;
                lastRspData = rsp_data;
                lastRspErr = rsp_err;
                lastRspCyc = cyc;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) rspLog.push_back(i);
            end
            if (expRsp != '0) begin
                checkOutput("rsp_data", rsp_data, mByte);
                checkOutput("rsp_err", rsp_err, mErr);
                mBusy = 1'b0;
                mFreeCyc = cyc + GAP + 1;
                mLock = (!mLast && !mErr) ? mOwner : -1;
            end
            if (drv_en) lastEnHighCyc = cyc;
        end
    end

    function automatic int grantCode();
        int c = 0;
        foreach (grantLog[i]) c = c * 16 + grantLog[i] + 1;
        return c;
    endfunction

    function automatic int rspCode();
        int c = 0;
        foreach (rspLog[i]) c = c * 16 + rspLog[i] + 1;
        return c;
    endfunction

    task automatic clearLogs();
        grantLog.delete();
        rspLog.delete();
        startCount = 0;
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < N; i++) if (reqQ[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic waitDone(input string name);
        int n = 0;
        @(negedge clk);
        while (!(queuesEmpty() && !mBusy && cyc > mFreeCyc + 1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int rspBefore;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] contention");
        drvLen = 4; drvByte = 8'h77; drvFill = 8'h5A; drvMode = 1'b0;
        clearLogs();
        for (int i = 0; i < N; i++) applyStimulus(i, 8'h40 + 8'(i), 1'b1);
        applyStimulus(0, 8'h44, 1'b1);
        waitDone("contention");
        checkOutput("contention_grants", grantCode(), 32'h12341);
        checkOutput("contention_rsp_order", rspCode(), 32'h12341);
        checkOutput("contention_rsp_data", lastRspData, 8'h77);

        $display("[TB] burst");
        drvLen = 3; drvByte = 8'hC4; drvFill = 8'h11;
        clearLogs();
        applyStimulus(1, 8'h10, 1'b0);
        applyStimulus(1, 8'h20, 1'b0);
        applyStimulus(1, 8'h30, 1'b1);
        applyStimulus(0, 8'h0F, 1'b1);
        waitDone("burst");
        checkOutput("burst_grants", grantCode(), 32'h2221);
        checkOutput("burst_rsp_order", rspCode(), 32'h2221);

        $display("[TB] single request");
        drvLen = 68; drvByte = 8'h3C; drvFill = 8'h00;
        clearLogs();
        applyStimulus(2, 8'hA5, 1'b1);
        waitDone("single");
        checkOutput("single_grant", (grantLog.size() == 1) ? grantLog[0] : 99, 2);
        checkOutput("single_starts", startCount, 1);
        checkOutput("single_start_data", lastStartData, 8'hA5);
        checkOutput("single_rsp_valid", lastRspValid, 4'b0100);
        checkOutput("single_rsp_data", lastRspData, 8'h3C);
        checkOutput("single_rsp_err", lastRspErr, 1'b0);
        checkOutput("single_latency", lastRspCyc - lastStartCyc, 70);

        $display("[TB] timeout");
        drvMode = 1'b1;
        clearLogs();
        applyStimulus(3, 8'hC3, 1'b0);
        applyStimulus(0, 8'h0F, 1'b1);
        waitDone("timeout");
        checkOutput("timeout_grants", grantCode(), 32'h41);
        checkOutput("timeout_rsp_err", lastRspErr, 1'b1);
        checkOutput("timeout_rsp_data", lastRspData, 8'h00);
        checkOutput("timeout_latency", lastRspCyc - lastStartCyc, 9);
        drvMode = 1'b0;

        $display("[TB] reset mid transfer");
        drvLen = 20; drvByte = 8'h99; drvFill = 8'h00;
        clearLogs();
        applyStimulus(2, 8'h5C, 1'b1);
        n = 0;
        while (!drv_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL reset_wait_en: drv_en never rose, required high");
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) reqQ[i].delete();
        rspBefore = rspCount;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("reset_no_rsp", rspCount, rspBefore);
        clearLogs();
        applyStimulus(3, 8'h33, 1'b1);
        applyStimulus(0, 8'h00, 1'b1);
        drvLen = 2;
        waitDone("after_reset");
        checkOutput("after_reset_grants", grantCode(), 32'h14);

        $display("[TB] response integrity");
        drvLen = 5; drvByte = 8'hFF; drvFill = 8'h00;
        clearLogs();
        applyStimulus(1, 8'h81, 1'b1);
        waitDone("integrity");
        checkOutput("integrity_rsp_valid", lastRspValid, 4'b0010);
        checkOutput("integrity_rsp_data", lastRspData, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
